bcd_stopwatch_4dig: RTL

- Four-digit BCD stopwatch/counter that drives the 7-segment decoders on the board.
- Takes the raw push-keys, debounces and edge-detects them, and divides the board clock into a count tick.
- Keeps four BCD digits, each presented as a 4-bit nibble that connects directly to one decoder instance per HEX display.
- Directly upstream of the segment decoders; the decoders are combinational, so digit outputs are registered here.

---
 rtl/bcd_stopwatch_4dig.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/bcd_stopwatch_4dig.sv
// Four-digit BCD stopwatch: debounced start/clear keys, prescaled count tick, registered digits.
// Define BCD_STOPWATCH_DOWN_EN to honour dir (count down with borrow); otherwise counts up only.
module bcd_stopwatch_4dig #(
  parameter int CLK_HZ     = 50000000,
  parameter int TICK_HZ    = 10,
  parameter int DEB_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_start_n,
  input  logic       key_clear_n,
  input  logic       dir,
  output logic       run,
  output logic       tick,
  output logic       ovf,
  output logic [3:0] d0,
  output logic [3:0] d1,
  output logic [3:0] d2,
  output logic [3:0] d3
);
  localparam int PS_DIV = CLK_HZ / TICK_HZ;
  localparam int PS_W   = (PS_DIV > 2) ? $clog2(PS_DIV) : 1;
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(PS_DIV - 1);
  localparam int DB_W   = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEB_CYCLES - 1);

  // Bit 0 = start key, bit 1 = clear key.
  logic [1:0]           key_raw;
  logic [1:0]           sync1_q, sync2_q;
  logic [1:0]           deb_q, deb_d, deb_prev_q;
  logic [1:0][DB_W-1:0] dbc_q, dbc_d;
  logic [1:0]           press;
  logic                 start_p, clr_p;

  logic                 run_q, run_d;
  logic                 tick_q, tick_d;
  logic                 ovf_q, ovf_d;
  logic [PS_W-1:0]      ps_q, ps_d;
  logic [15:0]          dig_q, dig_d;
  logic [16:0]          step_r;

  assign key_raw = {key_clear_n, key_start_n};
  assign press   = deb_prev_q & ~deb_q;
  assign start_p = press[0];
  assign clr_p   = press[1];

  function automatic logic [16:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      if (c) begin
        if (v[4*i +: 4] >= 4'd9) begin
          r[4*i +: 4] = '0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return {c, r};
  endfunction

`ifdef BCD_STOPWATCH_DOWN_EN
  function automatic logic [16:0] bcd_dec(input logic [15:0] v);
    logic [15:0] r;
    logic        b;
    r = v;
    b = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      if (b) begin
        if (v[4*i +: 4] == 4'd0 || v[4*i +: 4] > 4'd9) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return {b, r};
  endfunction
`else
  logic unused_dir;
  assign unused_dir = dir;
`endif

  always_comb begin
    deb_d = deb_q;
    dbc_d = '0;
    for (int unsigned k = 0; k < 2; k++) begin
      if (sync2_q[k] != deb_q[k]) begin
        if (dbc_q[k] == DB_MAX) deb_d[k] = sync2_q[k];
        else                    dbc_d[k] = dbc_q[k] + DB_W'(1);
      end
    end
  end

  // tick is registered, so the digits step one cycle after it; clear suppresses a coincident wrap.
  always_comb begin
    run_d  = run_q;
    ps_d   = ps_q;
    tick_d = 1'b0;
    dig_d  = dig_q;
    ovf_d  = ovf_q;
    step_r = bcd_inc(dig_q);
`ifdef BCD_STOPWATCH_DOWN_EN
    if (dir) step_r = bcd_dec(dig_q);
`endif
    if (clr_p) begin
      run_d = 1'b0;
      ps_d  = '0;
      dig_d = '0;
      ovf_d = 1'b0;
    end else begin
      if (start_p) run_d = ~run_q;
      if (run_q) begin
        if (ps_q == PS_MAX) begin
          ps_d   = '0;
          tick_d = 1'b1;
        end else begin
          ps_d = ps_q + PS_W'(1);
        end
      end
      if (tick_q) begin
        dig_d = step_r[15:0];
        ovf_d = ovf_q | step_r[16];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q    <= '1;
      sync2_q    <= '1;
      deb_q      <= '1;
      deb_prev_q <= '1;
      dbc_q      <= '0;
      run_q      <= 1'b0;
      tick_q     <= 1'b0;
      ovf_q      <= 1'b0;
      ps_q       <= '0;
      dig_q      <= '0;
    end else begin
      sync1_q    <= key_raw;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      dbc_q      <= dbc_d;
      run_q      <= run_d;
      tick_q     <= tick_d;
      ovf_q      <= ovf_d;
      ps_q       <= ps_d;
      dig_q      <= dig_d;
    end
  end

  assign run  = run_q;
  assign tick = tick_q;
  assign ovf  = ovf_q;
  assign d0   = dig_q[3:0];
  assign d1   = dig_q[7:4];
  assign d2   = dig_q[11:8];
  assign d3   = dig_q[15:12];
endmodule
